systolic_pe_db: RTL

- Parametrised weight-stationary MAC processing element for the systolic array.
- Generalised in data, accumulator and pipeline widths; adds valid tracking, stall and a double-buffered weight chain.
- While the array computes with the active weight, the next tile's weights shift down the column into a shadow register; a swap makes them active.
- Sits at every array node: activations flow east, partial sums flow south, weights shift south on their own chain.

---
 rtl/systolic_pe_db.sv | 98 +++++++++
 1 files changed

// File: rtl/systolic_pe_db.sv
// systolic_pe_db: weight-stationary MAC processing element with a double-buffered weight chain.
// Define SYSTOLIC_PE_SAT_EN for a saturating accumulate with a sticky sat_hit flag.
module systolic_pe_db #(
    parameter int DATA_W     = 16,
    parameter int ACC_W      = 40,
    parameter int PIPE_DEPTH = 3,
    parameter int SIGNED     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic [ACC_W-1:0]  in_sum,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_load,
    input  logic              w_swap,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_sum,
    output logic [DATA_W-1:0] w_out,
    output logic              sat_hit
);
    logic [DATA_W-1:0]                  r_shadow, r_active, r_w_out;
    logic [PIPE_DEPTH-1:0]              r_v;
    logic [PIPE_DEPTH-1:0][DATA_W-1:0]  r_d;
    logic [PIPE_DEPTH-1:0][ACC_W-1:0]   r_s;
    logic [ACC_W-1:0]                   w_prod_ext, w_sum;

    // Both updates use the pre-edge shadow, so a simultaneous swap takes the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow <= '0;
            r_active <= '0;
            r_w_out  <= '0;
        end else begin
            if (w_load) begin
                r_shadow <= w_in;
                r_w_out  <= r_shadow;
            end
            if (w_swap) r_active <= r_shadow;
        end
    end

    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [2*DATA_W-1:0] w_prod;
            assign w_prod     = (2*DATA_W)'($signed(in_data)) * (2*DATA_W)'($signed(r_active));
            assign w_prod_ext = ACC_W'(w_prod);
        end else begin : g_unsigned
            logic [2*DATA_W-1:0] w_prod;
            assign w_prod     = (2*DATA_W)'(in_data) * (2*DATA_W)'(r_active);
            assign w_prod_ext = ACC_W'(w_prod);
        end
    endgenerate

`ifdef SYSTOLIC_PE_SAT_EN
    logic [ACC_W:0] w_full;
    logic           w_ovf;
    logic           r_sat;
    assign w_full = {1'b0, in_sum} + {1'b0, w_prod_ext};
    assign w_ovf  = (SIGNED != 0) ? (in_sum[ACC_W-1] == w_prod_ext[ACC_W-1]) && (w_full[ACC_W-1] != in_sum[ACC_W-1])
                                  : w_full[ACC_W];
    assign w_sum  = !w_ovf ? w_full[ACC_W-1:0] :
                    (SIGNED == 0) ? '1 : {in_sum[ACC_W-1], {(ACC_W-1){~in_sum[ACC_W-1]}}};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_sat <= 1'b0;
        else if (enable && in_valid && w_ovf) r_sat <= 1'b1;
    end
    assign sat_hit = r_sat;
`else
    assign w_sum   = in_sum + w_prod_ext;
    assign sat_hit = 1'b0;
`endif

    // Bubbles are zeroed on entry so the output registers never expose stale data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v <= '0;
            r_d <= '0;
            r_s <= '0;
        end else if (enable) begin
            r_v[0] <= in_valid;
            r_d[0] <= in_valid ? in_data : '0;
            r_s[0] <= in_valid ? w_sum : '0;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_v[i] <= r_v[i-1];
                r_d[i] <= r_d[i-1];
                r_s[i] <= r_s[i-1];
            end
        end
    end

    assign out_valid = r_v[PIPE_DEPTH-1];
    assign out_data  = r_d[PIPE_DEPTH-1];
    assign out_sum   = r_s[PIPE_DEPTH-1];
    assign w_out     = r_w_out;
endmodule
